ex_div_issue: RTL

//  EX-stage front end for the iterative divider. Accepts DIV/DIVU from the EX

---
 rtl/ex_div_issue_if.sv | 43 ++++
 rtl/ex_div_issue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ex_div_issue_if.sv
// ex_div_issue_if
//   Handshake bundle between the EX-stage divide issue logic and the iterative
//   divider.
//   master : issue side (drives start/annul/signed/operands, reads ended/result)
//   slave  : divider side (reads start/annul/signed/operands, drives ended/result)
//   div_start    launch request, held high for the whole operation
//   div_annul    one-cycle kill of the in-flight divide
//   div_signed   1 = signed divide
//   div_operand1 dividend
//   div_operand2 divisor
//   div_ended    divider done, held until div_start drops
//   div_result   {remainder, quotient}, valid while div_ended = 1
interface ex_div_issue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      div_start;
    logic                      div_annul;
    logic                      div_signed;
    logic [DATA_WIDTH-1:0]     div_operand1;
    logic [DATA_WIDTH-1:0]     div_operand2;
    logic                      div_ended;
    logic [2*DATA_WIDTH-1:0]   div_result;

    modport master (
        output div_start,
        output div_annul,
        output div_signed,
        output div_operand1,
        output div_operand2,
        input  div_ended,
        input  div_result
    );

    modport slave (
        input  div_start,
        input  div_annul,
        input  div_signed,
        input  div_operand1,
        input  div_operand2,
        output div_ended,
        output div_result
    );
endinterface

// File: rtl/ex_div_issue.sv
// ex_div_issue
//   EX-stage front end for the iterative divider. Launches the divider with
//   registered operands, stalls the pipeline while the divide is in flight,
//   returns {hi, lo} as a one-cycle HI/LO write, and handles flush, back-to-back
//   divides and a watchdog timeout.
//
//   clock              rising-edge clock
//   reset              asynchronous, active-high
//   is_div             EX holds a DIV/DIVU (level, held while stalled)
//   is_signed          1 = DIV, 0 = DIVU
//   operand1/operand2  dividend / divisor from EX
//   is_flush           pipeline flush, kills the in-flight divide
//   div_bus            divider handshake (master side)
//   stall_request      combinational hold of IF/ID/EX
//   hilo_write_enable  combinational one-cycle HI/LO write strobe
//   hi_data/lo_data    registered remainder / quotient
//   div_error          sticky watchdog flag, cleared only by reset
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | divider free, waiting for a DIV in EX
//   ST_RUN   | div_start high, waiting for div_ended / flush / timeout
//   ST_DONE  | result registered, HI/LO write strobe, instruction retires
//   ST_DRAIN | div_start low, waiting for the divider to drop div_ended
module ex_div_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  is_div,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic                  is_flush,
    ex_div_issue_if.master        div_bus,
    output logic                  stall_request,
    output logic                  hilo_write_enable,
    output logic [DATA_WIDTH-1:0] hi_data,
    output logic [DATA_WIDTH-1:0] lo_data,
    output logic                  div_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      run_cnt;
    logic                  start_q;
    logic                  annul_q;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  error_q;

    logic launch;
    logic finish;
    logic abort;
    logic timeout_hit;
    logic stall_c;
    logic hwe_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        finish      = 1'b0;
        abort       = 1'b0;
        timeout_hit = 1'b0;
        stall_c     = 1'b0;
        hwe_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_div && !is_flush) begin
                    launch    = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // flush beats a completing divide, which beats the watchdog
                if (is_flush) begin
                    abort     = 1'b1;
                    state_nxt = ST_DRAIN;
                end else if (div_bus.div_ended) begin
                    finish    = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (run_cnt == CNT_LAST) begin
                    abort       = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = ST_DRAIN;
                end else begin
                    stall_c = 1'b1;
                end
            end
            ST_DONE: begin
                hwe_c     = !is_flush;
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // a following DIV already in EX must wait for the divider to free up
                stall_c = is_div;
                if (!div_bus.div_ended) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt  <= '0;
            start_q  <= 1'b0;
            annul_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            error_q  <= 1'b0;
        end else begin
            annul_q <= abort;
            if (launch) begin
                op1_q    <= operand1;
                op2_q    <= operand2;
                signed_q <= is_signed;
                start_q  <= 1'b1;
                run_cnt  <= '0;
            end else if (state == ST_RUN) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
            if (finish || abort) begin
                start_q <= 1'b0;
            end
            if (finish) begin
                hi_q <= div_bus.div_result[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_q <= div_bus.div_result[DATA_WIDTH-1:0];
            end
            if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign div_bus.div_start    = start_q;
    assign div_bus.div_annul    = annul_q;
    assign div_bus.div_signed   = signed_q;
    assign div_bus.div_operand1 = op1_q;
    assign div_bus.div_operand2 = op2_q;

    // combinational outputs are forced low while reset is held so a DIV sitting
    // in EX cannot raise a stall before the block is out of reset
    assign stall_request     = stall_c && !reset;
    assign hilo_write_enable = hwe_c && !reset;
    assign hi_data           = hi_q;
    assign lo_data           = lo_q;
    assign div_error         = error_q;

endmodule
